// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  localparam int DMEM_WORDS  = 100;
  localparam int DMEM_DATA_W = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester handshake and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0, req1;
  logic              lock0, lock1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              err0, err1;
  logic [ADDR_W-1:0] mem_A;
  logic [DATA_W-1:0] mem_WD;
  logic              mem_WE;
  logic [DATA_W-1:0] mem_RD;

  // Requesters and the memory itself
  modport master (
    output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, mem_RD,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
           mem_A, mem_WD, mem_WE
  );

  // Arbiter
  modport slave (
    input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, mem_RD,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
           mem_A, mem_WD, mem_WE
  );
endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational winner select: round-robin when idle, owner-first when locked,
// with the waiting port forced through once the burst counter saturates.
module dmem_rr_pick
  import dmem_pkg::*;
#(
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 4
) (
  input  logic             req0,
  input  logic             req1,
  input  arb_state_t       state,
  input  logic             last,
  input  logic [CNT_W-1:0] burst_cnt,
  output logic             win_valid,
  output logic             win_port
);
  logic starve;

  // Pick the winning port; port 0 is reported when nobody requests
  always_comb begin
    starve    = (burst_cnt == CNT_W'(MAX_BURST));
    win_valid = req0 | req1;
    win_port  = PORT_CPU;
    case (state)
      LOCK0:   win_port = req1 & (~req0 | starve);
      LOCK1:   win_port = req1 & ~(req0 & starve);
      default: win_port = (req0 & req1) ? ~last : (req1 & ~req0);
    endcase
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: CPU on port 0,
// debug/loader on port 1. Grants combinationally, returns read data and
// out-of-range errors one cycle after the grant.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = DMEM_DATA_W,
  parameter int MEM_WORDS = DMEM_WORDS,
  parameter int MAX_BURST = 8
) (
  input logic           CLK,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  localparam int                CNT_W      = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(MAX_BURST);
  localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

  arb_state_t        state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              pick_valid, pick_port;
  logic              grant, gnt0, gnt1;
  logic              win_we, win_lock, other_req, in_range;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  logic              rvalid0_q, rvalid1_q, err0_q, err1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  dmem_rr_pick #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_pick (
    .req0      (bus.req0),
    .req1      (bus.req1),
    .state     (state_q),
    .last      (last_q),
    .burst_cnt (cnt_q),
    .win_valid (pick_valid),
    .win_port  (pick_port)
  );

  // Route the winner's request to the memory; grants are masked during reset
  always_comb begin
    win_we    = bus.we0;
    win_lock  = bus.lock0;
    win_addr  = bus.addr0;
    win_wdata = bus.wdata0;
    other_req = bus.req1;
    if (pick_port == PORT_DBG) begin
      win_we    = bus.we1;
      win_lock  = bus.lock1;
      win_addr  = bus.addr1;
      win_wdata = bus.wdata1;
      other_req = bus.req0;
    end
    in_range   = ({1'b0, win_addr} < ADDR_LIMIT);
    grant      = pick_valid & reset;
    gnt0       = grant & (pick_port == PORT_CPU);
    gnt1       = grant & (pick_port == PORT_DBG);
    bus.gnt0   = gnt0;
    bus.gnt1   = gnt1;
    bus.mem_A  = win_addr;
    bus.mem_WD = win_wdata;
    bus.mem_WE = grant & win_we & in_range;
  end

  // Lock ownership, round-robin pointer and burst counter for the next cycle.
  // The counter includes the grant that takes the lock, so MAX_BURST locked
  // grants go through before the waiting port is forced in.
  always_comb begin
    state_d = IDLE;
    last_d  = last_q;
    cnt_d   = '0;
    if (grant) begin
      last_d = pick_port;
      if (win_lock) begin
        state_d = (pick_port == PORT_DBG) ? LOCK1 : LOCK0;
        if (other_req) begin
          if (state_q == state_d)
            cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
          else
            cnt_d = CNT_W'(1);
        end
      end
    end
  end

  // Arbitration state registers
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= PORT_DBG;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Read-data return and out-of-range error pulses
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= gnt0 & ~win_we;
      rvalid1_q <= gnt1 & ~win_we;
      err0_q    <= gnt0 & ~in_range;
      err1_q    <= gnt1 & ~in_range;
      if (gnt0 && !win_we) rdata0_q <= in_range ? bus.mem_RD : '0;
      if (gnt1 && !win_we) rdata1_q <= in_range ? bus.mem_RD : '0;
    end
  end

  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;
  assign bus.err0    = err0_q;
  assign bus.err1    = err1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus legal random traffic,
// checked every cycle against a transaction-level model of the arbiter.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int WORDS = 100;
  localparam int MB    = 8;

  logic CLK   = 1'b0;
  logic reset = 1'b0;
  always #5 CLK = ~CLK;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MEM_WORDS (WORDS),
    .MAX_BURST (MB)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  // Memory attached to the arbiter; out-of-range reads return garbage
  logic [DW-1:0] env_mem [0:WORDS-1];
  assign bus.mem_RD = (bus.mem_A < 32'(WORDS)) ? env_mem[bus.mem_A[6:0]] : 32'hBAD0_BAD0;
  always @(posedge CLK)
    if (bus.mem_WE && bus.mem_A < 32'(WORDS)) env_mem[bus.mem_A[6:0]] <= bus.mem_WD;

  function automatic logic [DW-1:0] init_word(input int i);
    return (DW'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
  endfunction

  initial for (int i = 0; i < WORDS; i++) env_mem[i] <= init_word(i);

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int            m_owner;          // -1 = no lock held, else owning port
  int            m_last;           // port granted most recently
  int            m_streak;         // locked grants in a row while the other port waited
  logic [DW-1:0] m_mem [0:WORDS-1];
  logic          m_rvalid [2];
  logic [DW-1:0] m_rdata  [2];
  logic          m_err    [2];
  int            last_w = -1;

  logic          s_req [2], s_lock [2], s_we [2];
  logic [AW-1:0] s_addr [2];
  logic [DW-1:0] s_wdata [2];

  function automatic void model_reset();
    m_owner  = -1;
    m_last   = 1;
    m_streak = 0;
    for (int p = 0; p < 2; p++) begin
      m_rvalid[p] = 1'b0;
      m_rdata[p]  = '0;
      m_err[p]    = 1'b0;
    end
  endfunction

  function automatic int model_pick();
    int o;
    if (!s_req[0] && !s_req[1]) return -1;
    if (m_owner >= 0) begin
      o = m_owner;
      if (s_req[o] && !(s_req[1-o] && m_streak >= MB)) return o;
      return 1 - o;
    end
    if (s_req[0] && s_req[1]) return 1 - m_last;
    return s_req[0] ? 0 : 1;
  endfunction

  function automatic void model_step(input int w);
    logic inr;
    int   idx;
    for (int p = 0; p < 2; p++) begin
      m_rvalid[p] = 1'b0;
      m_err[p]    = 1'b0;
    end
    if (w < 0) begin
      m_owner  = -1;
      m_streak = 0;
      return;
    end
    inr = (s_addr[w] < 32'(WORDS));
    idx = inr ? int'(s_addr[w]) : 0;
    if (s_we[w]) begin
      if (inr) m_mem[idx] = s_wdata[w];
    end else begin
      m_rvalid[w] = 1'b1;
      m_rdata[w]  = inr ? m_mem[idx] : '0;
    end
    m_err[w] = !inr;
    if (s_lock[w]) begin
      if (s_req[1-w]) m_streak = (m_owner == w) ? ((m_streak < MB) ? m_streak + 1 : MB) : 1;
      else            m_streak = 0;
      m_owner = w;
    end else begin
      m_owner  = -1;
      m_streak = 0;
    end
    m_last = w;
  endfunction

  // Compare process: outputs checked mid-cycle, model advanced at the edge
  initial begin
    int       w;
    logic     exp_we;
    model_reset();
    for (int i = 0; i < WORDS; i++) m_mem[i] = init_word(i);
    forever begin
      @(negedge CLK);
      s_req[0] = bus.req0;   s_req[1] = bus.req1;
      s_lock[0] = bus.lock0; s_lock[1] = bus.lock1;
      s_we[0] = bus.we0;     s_we[1] = bus.we1;
      s_addr[0] = bus.addr0; s_addr[1] = bus.addr1;
      s_wdata[0] = bus.wdata0; s_wdata[1] = bus.wdata1;
      if (!reset) model_reset();
      w = reset ? model_pick() : -1;
      exp_we = 1'b0;
      if (w >= 0) exp_we = s_we[w] && (s_addr[w] < 32'(WORDS));
      check("gnt0", bus.gnt0, w == 0);
      check("gnt1", bus.gnt1, w == 1);
      check("mem_WE", bus.mem_WE, exp_we);
      if (w >= 0) begin
        check("mem_A", bus.mem_A, s_addr[w]);
        check("mem_WD", bus.mem_WD, s_wdata[w]);
      end else if (reset) begin
        check("mem_A_idle", bus.mem_A, s_addr[0]);
        check("mem_WD_idle", bus.mem_WD, s_wdata[0]);
      end
      check("rvalid0", bus.rvalid0, m_rvalid[0]);
      check("rvalid1", bus.rvalid1, m_rvalid[1]);
      check("rdata0", bus.rdata0, m_rdata[0]);
      check("rdata1", bus.rdata1, m_rdata[1]);
      check("err0", bus.err0, m_err[0]);
      check("err1", bus.err1, m_err[1]);
      @(posedge CLK);
      if (reset) model_step(w);
      else       model_reset();
      last_w = w;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int p, input logic rq, input logic lk, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      bus.req0 = rq; bus.lock0 = lk; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = rq; bus.lock1 = lk; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic idle_all();
    drive(0, 0, 0, 0, '0, '0);
    drive(1, 0, 0, 0, '0, '0);
  endtask

  initial begin
    logic          pend [2];
    logic          rq, lk, w;
    logic [AW-1:0] a;

    idle_all();
    // Reset: requests are ignored and registered outputs are clear
    tick();
    drive(0, 1, 0, 1, 3, 32'h1111_1111);
    drive(1, 1, 0, 0, 4, '0);
    #3;
    check("rst_gnt0", bus.gnt0, 0);
    check("rst_gnt1", bus.gnt1, 0);
    check("rst_memwe", bus.mem_WE, 0);
    check("rst_rvalid1", bus.rvalid1, 0);
    tick();
    idle_all();
    reset = 1'b1;

    // Single write on port 0, read back on port 1
    drive(0, 1, 0, 1, 5, 32'hDEAD_BEEF);
    #3;
    check("wr_gnt0", bus.gnt0, 1);
    check("wr_memwe", bus.mem_WE, 1);
    check("wr_memA", bus.mem_A, 5);
    tick();
    drive(0, 0, 0, 0, '0, '0);
    drive(1, 1, 0, 0, 5, '0);
    #3;
    check("rd_gnt1", bus.gnt1, 1);
    tick();
    idle_all();
    #3;
    check("rd_rvalid1", bus.rvalid1, 1);
    check("rd_rdata1", bus.rdata1, 32'hDEAD_BEEF);

    // Tie right after reset alternates starting with port 0
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    drive(0, 1, 0, 0, 1, '0);
    drive(1, 1, 0, 0, 2, '0);
    for (int i = 0; i < 4; i++) begin
      #3;
      check("tie_gnt0", bus.gnt0, (i % 2) == 0);
      check("tie_gnt1", bus.gnt1, (i % 2) == 1);
      tick();
    end

    // Locked burst on port 1 against a waiting port 0
    drive(0, 1, 0, 0, 3, '0);
    drive(1, 1, 1, 0, 4, '0);
    for (int i = 0; i < 20; i++) begin
      #3;
      check("burst_gnt0", bus.gnt0, (i % 9) == 0);
      check("burst_gnt1", bus.gnt1, (i % 9) != 0);
      tick();
    end
    idle_all();
    tick();

    // Out-of-range write then read
    drive(0, 1, 0, 1, 100, 32'h1234_5678);
    #3;
    check("oor_gnt0", bus.gnt0, 1);
    check("oor_memwe", bus.mem_WE, 0);
    tick();
    drive(0, 1, 0, 0, 150, '0);
    #3;
    check("oor_err_wr", bus.err0, 1);
    check("oor_rvalid_wr", bus.rvalid0, 0);
    tick();
    idle_all();
    #3;
    check("oor_rvalid", bus.rvalid0, 1);
    check("oor_rdata", bus.rdata0, 0);
    check("oor_err_rd", bus.err0, 1);

    // Async reset in the middle of a port 1 burst with a write pending
    tick();
    drive(1, 1, 1, 0, 6, '0);
    tick();
    tick();
    drive(1, 1, 1, 1, 7, 32'hCAFE_F00D);
    drive(0, 1, 0, 0, 8, '0);
    #1;
    reset = 1'b0;
    #1;
    check("rstb_gnt0", bus.gnt0, 0);
    check("rstb_gnt1", bus.gnt1, 0);
    check("rstb_memwe", bus.mem_WE, 0);
    tick();
    reset = 1'b1;
    #3;
    check("rstb_tie_gnt0", bus.gnt0, 1);
    tick();
    drive(0, 0, 0, 0, '0, '0);
    tick();
    idle_all();
    tick();

    // One-cycle withdrawn request on port 1 while port 0 holds the lock
    drive(0, 1, 1, 0, 10, '0);
    tick();
    tick();
    drive(1, 1, 0, 1, 9, 32'h55AA_55AA);
    #3;
    check("wd_gnt1", bus.gnt1, 0);
    check("wd_gnt0", bus.gnt0, 1);
    check("wd_memwe", bus.mem_WE, 0);
    tick();
    drive(1, 0, 0, 0, '0, '0);
    #3;
    check("wd_rvalid1", bus.rvalid1, 0);
    tick();
    idle_all();
    tick();

    // Random legal traffic with occasional asynchronous resets
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (reset == 1'b0) reset = 1'b1;
      for (int p = 0; p < 2; p++) begin
        if (last_w == p) pend[p] = 1'b0;
        if (pend[p]) begin
          if ($urandom_range(15) == 0) begin
            drive(p, 0, 0, 0, '0, '0);
            pend[p] = 1'b0;
          end
        end else begin
          rq = ($urandom_range(3) != 0);
          lk = 1'($urandom_range(1));
          w  = 1'($urandom_range(1));
          case ($urandom_range(9))
            7, 8:    a = AW'($urandom_range(104, 95));
            9:       a = $urandom;
            default: a = AW'($urandom_range(15));
          endcase
          drive(p, rq, lk, w, a, $urandom);
          pend[p] = rq;
        end
      end
      if ($urandom_range(299) == 0) begin
        #1;
        reset = 1'b0;
      end
      tick();
    end
    reset = 1'b1;
    idle_all();
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
